main_memory: RTL and testbench
==============================

// Module: main_memory
// PURPOSE
//   Byte-addressable backing store (main memory) that sits below the cache hierarchy.
//   Single read/write port: asynchronous (combinational) byte read, synchronous byte write.
//   Also exposes an aligned multi-byte line read for cache refills.
//   Contents are initialised on reset to a known address pattern so that reads are deterministic.
// PARAMETERS
//   DEPTH       1024  number of bytes implemented; valid addresses are 0..DEPTH-1
//   LINE_BYTES  4     bytes per cache line on line_out; power of 2, must divide DEPTH
// PORTS
//   clk         in   1               single clock; writes occur on the rising edge
//   reset       in   1               asynchronous, active-high reset
//   Address     in   32              byte address for the read and the write
//   Data        in   8               write data
//   isWrite     in   1               1 = write Data to Address on the next rising clk edge
//   outputdata  out  8               byte at Address (combinational)
//   line_out    out  8*LINE_BYTES    line containing Address, aligned down to LINE_BYTES; byte k at bits [8k+7:8k]
// BEHAVIOUR
//   - Storage is an array mem[0..DEPTH-1] of 8-bit bytes.
//   - Reset: while reset=1 (asynchronous, independent of clk), every mem[i] <= i[7:0]
//     (e.g. mem[6]=8'h06, mem[300]=8'h2C). Writes are blocked while reset is high.
//     Outputs follow the reset contents combinationally (no separate output register).
//   - Read path, zero latency: outputdata = mem[Address] when Address < DEPTH, else 8'h00.
//     The upper address bits do not alias into the array.
//   - line_out: base = Address & ~(LINE_BYTES-1); byte k = mem[base+k].
//     Any byte whose address is >= DEPTH reads as 8'h00.
//   - Write path: on posedge clk with reset=0 and isWrite=1 and Address < DEPTH, mem[Address] <= Data.
//     Out-of-range writes are silently ignored. isWrite=0 leaves the memory unchanged.
//   - Read-during-write: before the edge, outputdata shows the old byte. After the edge, it shows
//     Data in the same cycle, because the read path is combinational.
//   - Consecutive writes to the same address: the last edge wins.
//     Address, Data and isWrite may change every cycle; there is no handshake and no busy state.
//   - Reset asserted mid-operation: a write pending on the same edge is discarded and contents return
//     to the init pattern. After reset deasserts, the first write takes effect at the next posedge.
//   - No X propagation: every output is fully defined for every Address value.
// TESTING
//   1. Reset, Address=6, isWrite=0, Data=3, wait 10 units -> outputdata=8'b00000110 with no write performed.
//   2. Address=6, Data=8'hA5, isWrite=1, one posedge -> outputdata=8'hA5. Then isWrite=0, Address=7 -> 8'h07.
//   3. Address=DEPTH (1024), Data=8'hFF, isWrite=1, one posedge -> outputdata=8'h00. Then Address=0 -> 8'h00
//      (the write did not wrap).
//   4. After reset, Address=9, LINE_BYTES=4 -> line_out=32'h0B0A0908.
//      Write 8'h55 to address 10 -> line_out=32'h0B550908.
//   5. Write 8'h3C to address 300, then pulse reset asynchronously between edges -> outputdata at 300 reads 8'h2C
//      immediately, without waiting for a clk edge.
//   6. Address=0xFFFF_FFFF -> outputdata=8'h00 and line_out=0. Back-to-back writes of 8'h11 then 8'h22
//      to address 5 on two edges -> reads 8'h22.

Source files
------------

// File: rtl/main_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : main_memory_if
//  Description : Bus bundle for the main_memory backing store. Carries the
//                byte address, write data and write strobe from the requester,
//                and the combinational byte and line read data back.
//                  Address    [31:0]             byte address (read and write)
//                  Data       [7:0]              write data
//                  isWrite                       write strobe, sampled on clk
//                  outputdata [7:0]              byte at Address
//                  line_out   [8*LINE_BYTES-1:0] aligned line holding Address
//  Revision    : 1.0 - initial release
// ============================================================================
interface main_memory_if #(
  parameter int LINE_BYTES = 4
);
  logic [31:0]             Address;
  logic [7:0]              Data;
  logic                    isWrite;
  logic [7:0]              outputdata;
  logic [8*LINE_BYTES-1:0] line_out;

  modport master (
    output Address,
    output Data,
    output isWrite,
    input  outputdata,
    input  line_out
  );

  modport slave (
    input  Address,
    input  Data,
    input  isWrite,
    output outputdata,
    output line_out
  );
endinterface
`default_nettype wire

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
//  Module      : main_memory
//  Description : Byte-addressable backing store below the cache hierarchy.
//                Combinational byte read, synchronous byte write, plus an
//                aligned multi-byte line read for cache refills. Reset loads
//                every byte with the low 8 bits of its own address.
//                  clk    - write clock (rising edge)
//                  reset  - asynchronous, active-high; restores init pattern
//                  bus    - main_memory_if slave (Address, Data, isWrite,
//                           outputdata, line_out)
//  Revision    : 1.0 - initial release
// ============================================================================
module main_memory #(
  parameter int DEPTH      = 1024,
  parameter int LINE_BYTES = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  main_memory_if.slave       bus
);

  localparam int          c_AW       = $clog2(DEPTH);
  localparam logic [31:0] c_DEPTH32  = 32'(DEPTH);
  localparam logic [31:0] c_LINE_MSK = ~(32'(LINE_BYTES) - 32'd1);

  logic [7:0]              r_mem [DEPTH];
  logic                    w_in_range;
  logic                    w_wr_en;
  logic [c_AW-1:0]         w_idx;
  logic [31:0]             w_base;
  logic [8*LINE_BYTES-1:0] w_line;

  // The full 32-bit compare keeps upper address bits from aliasing.
  assign w_in_range = (bus.Address < c_DEPTH32);
  assign w_idx      = bus.Address[c_AW-1:0];
  assign w_wr_en    = bus.isWrite && w_in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'(i);
      end
    end else if (w_wr_en) begin
      r_mem[w_idx] <= bus.Data;
    end
  end

  assign bus.outputdata = w_in_range ? r_mem[w_idx] : 8'h00;

  // Line read: each byte is range-checked on its own so a line straddling
  // or lying beyond DEPTH never returns undefined data.
  assign w_base = bus.Address & c_LINE_MSK;

  for (genvar k = 0; k < LINE_BYTES; k++) begin : g_line
    logic [31:0] w_addr;
    assign w_addr = w_base + 32'(k);
    assign w_line[8*k +: 8] = (w_addr < c_DEPTH32) ? r_mem[w_addr[c_AW-1:0]] : 8'h00;
  end

  assign bus.line_out = w_line;

endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_memory
//  Description : Directed self-checking bench for main_memory with
//                hand-computed expected values (DEPTH=1024, LINE_BYTES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_main_memory;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  main_memory_if #(.LINE_BYTES(4)) bus ();

  main_memory #(
    .DEPTH      (1024),
    .LINE_BYTES (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One write on the next rising edge; outputs sampled 1 ns after the edge.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.Address = addr;
    bus.Data    = data;
    bus.isWrite = 1'b1;
    @(posedge clk);
    #1;
    bus.isWrite = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] addr);
    bus.Address = addr;
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    bus.Address = 32'd6;
    bus.Data    = 8'd3;
    bus.isWrite = 1'b0;
    #10;
    check("reset_byte6", 32'(bus.outputdata), 32'h06);
    check("reset_line6", bus.line_out, 32'h07060504);

    // Write strobe held during reset must not land.
    bus.isWrite = 1'b1;
    bus.Data    = 8'hEE;
    @(posedge clk); #1;
    check("reset_blocks_wr", 32'(bus.outputdata), 32'h06);
    @(negedge clk);
    bus.isWrite = 1'b0;
    reset       = 1'b0;
    #1;
    check("post_reset_byte6", 32'(bus.outputdata), 32'h06);

    // Read-during-write: old byte before the edge, new byte right after.
    @(negedge clk);
    bus.Address = 32'd6;
    bus.Data    = 8'hA5;
    bus.isWrite = 1'b1;
    #1;
    check("rdw_before_edge", 32'(bus.outputdata), 32'h06);
    @(posedge clk); #1;
    check("wr_byte6", 32'(bus.outputdata), 32'hA5);
    bus.isWrite = 1'b0;
    set_addr(32'd7);
    check("rd_byte7", 32'(bus.outputdata), 32'h07);

    // Out-of-range write ignored, no wrap.
    do_write(32'd1024, 8'hFF);
    check("oor_rd", 32'(bus.outputdata), 32'h00);
    check("oor_line", bus.line_out, 32'h00000000);
    set_addr(32'd0);
    check("no_wrap_byte0", 32'(bus.outputdata), 32'h00);
    set_addr(32'd1030);
    check("no_alias_1030", 32'(bus.outputdata), 32'h00);
    set_addr(32'd1021);
    check("last_line", bus.line_out, 32'hFFFEFDFC);

    // Line read and line update.
    set_addr(32'd9);
    check("line9", bus.line_out, 32'h0B0A0908);
    do_write(32'd10, 8'h55);
    set_addr(32'd9);
    check("line9_after_wr", bus.line_out, 32'h0B550908);

    // isWrite=0 leaves memory unchanged even with new Data.
    @(negedge clk);
    bus.Data = 8'h99;
    @(posedge clk); #1;
    check("no_wr_strobe", bus.line_out, 32'h0B550908);

    // Async reset between edges restores the pattern immediately.
    do_write(32'd300, 8'h3C);
    check("wr_300", 32'(bus.outputdata), 32'h3C);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_300", 32'(bus.outputdata), 32'h2C);
    set_addr(32'd9);
    check("async_rst_line9", bus.line_out, 32'h0B0A0908);
    set_addr(32'd6);
    check("async_rst_byte6", 32'(bus.outputdata), 32'h06);
    #1;
    reset = 1'b0;

    // Reset covering a write edge discards the write; next edge lands it.
    @(negedge clk);
    bus.Address = 32'd20;
    bus.Data    = 8'h77;
    bus.isWrite = 1'b1;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_drops_wr", 32'(bus.outputdata), 32'h14);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("first_wr_after_rst", 32'(bus.outputdata), 32'h77);
    bus.isWrite = 1'b0;

    // Top of address space.
    set_addr(32'hFFFF_FFFF);
    check("max_addr_byte", 32'(bus.outputdata), 32'h00);
    check("max_addr_line", bus.line_out, 32'h00000000);

    // Back-to-back writes, last edge wins.
    @(negedge clk);
    bus.Address = 32'd5;
    bus.Data    = 8'h11;
    bus.isWrite = 1'b1;
    @(posedge clk); #1;
    check("b2b_first", 32'(bus.outputdata), 32'h11);
    @(negedge clk);
    bus.Data = 8'h22;
    @(posedge clk); #1;
    bus.isWrite = 1'b0;
    check("b2b_second", 32'(bus.outputdata), 32'h22);
    set_addr(32'd4);
    check("b2b_line", bus.line_out, 32'h07062204);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
